// File: rtl/doorlock_pkg.sv
// rtl/doorlock_pkg.sv - shared state codes and keypad constants for the door lock
package doorlock_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] KEY_NONE = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_ENTRY       = 3'd1,
        ST_CHECK       = 3'd2,
        ST_UNLOCKED    = 3'd3,
        ST_LOCKOUT     = 3'd4,
        ST_SET_NEW     = 3'd5,
        ST_SET_CONFIRM = 3'd6
    } state_t;

    function automatic logic is_digit(input logic [DIGIT_W-1:0] idx);
        return idx <= 4'd9;
    endfunction

endpackage

// File: rtl/doorlock_if.sv
// rtl/doorlock_if.sv - keypad events in, lock status out
interface doorlock_if;

    logic       input_v;
    logic [3:0] index;
    logic       btn_enter;
    logic       btn_clear;
    logic       btn_setpw;
    logic       unlock;
    logic       alarm;
    logic       ack;
    logic       err;
    logic [3:0] digit_cnt;
    logic [3:0] fail_cnt;
    logic [2:0] state;

    modport master (
        output input_v, index, btn_enter, btn_clear, btn_setpw,
        input  unlock, alarm, ack, err, digit_cnt, fail_cnt, state
    );

    modport slave (
        input  input_v, index, btn_enter, btn_clear, btn_setpw,
        output unlock, alarm, ack, err, digit_cnt, fail_cnt, state
    );

endinterface

// File: rtl/doorlock_pin_buffer.sv
// rtl/doorlock_pin_buffer.sv - digit shift register with count, copy-load and equality compare
module doorlock_pin_buffer
    import doorlock_pkg::*;
#(
    parameter int PIN_LEN = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         clr,
    input  logic                         shift_en,
    input  logic [DIGIT_W-1:0]           din,
    input  logic                         load_en,
    input  logic [PIN_LEN*DIGIT_W-1:0]   load_data,
    input  logic [PIN_LEN*DIGIT_W-1:0]   cmp_data,
    output logic [PIN_LEN*DIGIT_W-1:0]   data,
    output logic [3:0]                   cnt,
    output logic                         eq
);

    localparam int W = PIN_LEN * DIGIT_W;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data <= '0;
            cnt  <= '0;
        end else if (clr) begin
            data <= '0;
            cnt  <= '0;
        end else if (load_en) begin
            data <= load_data;
            cnt  <= 4'(PIN_LEN);
        end else if (shift_en) begin
            // newest digit lands in the LS nibble, first digit ends up in the MS nibble
            data <= W'({data, din});
            cnt  <= cnt + 4'd1;
        end
    end

    assign eq = (data == cmp_data);

endmodule

// File: rtl/doorlock_ctrl.sv
// rtl/doorlock_ctrl.sv - PIN entry, unlock timing, lockout and PIN change sequencing
module doorlock_ctrl
    import doorlock_pkg::*;
#(
    parameter int                           PIN_LEN        = 4,
    parameter int                           MAX_FAIL       = 3,
    parameter int                           UNLOCK_CYCLES  = 1000,
    parameter int                           LOCKOUT_CYCLES = 5000,
    parameter int                           ENTRY_TIMEOUT  = 2000,
    parameter logic [PIN_LEN*DIGIT_W-1:0]   DEFAULT_PIN    = 16'h1234
) (
    input  logic       clk,
    input  logic       rstn,
    doorlock_if.slave  bus
);

    localparam int W    = PIN_LEN * DIGIT_W;
    localparam int TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES)
                        ? ((UNLOCK_CYCLES > ENTRY_TIMEOUT) ? UNLOCK_CYCLES : ENTRY_TIMEOUT)
                        : ((LOCKOUT_CYCLES > ENTRY_TIMEOUT) ? LOCKOUT_CYCLES : ENTRY_TIMEOUT);
    localparam int TW   = $clog2(TMAX + 1);

    // timer holds remaining cycles minus one, so a state lasts exactly N cycles
    localparam logic [TW-1:0] T_UNLOCK  = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] T_LOCKOUT = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] T_ENTRY   = TW'(ENTRY_TIMEOUT - 1);

    state_t         state_q, state_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [3:0]     fail_q, fail_d;
    logic           ack_q, ack_d, err_q, err_d;
    logic           match_q;
    logic [W-1:0]   stored_q;

    logic           e_clr, e_shift, c_clr, c_load, pin_we;
    logic [W-1:0]   e_data, c_data;
    logic [3:0]     e_cnt, c_cnt;
    logic           e_eq, c_eq, e_full, c_full, timer_zero;
    logic           ev_clr, ev_ent, ev_set, ev_dig;

    doorlock_pin_buffer #(.PIN_LEN(PIN_LEN)) u_entry_buf (
        .clk(clk), .rstn(rstn), .clr(e_clr), .shift_en(e_shift), .din(bus.index),
        .load_en(1'b0), .load_data('0), .cmp_data(stored_q),
        .data(e_data), .cnt(e_cnt), .eq(e_eq)
    );

    doorlock_pin_buffer #(.PIN_LEN(PIN_LEN)) u_confirm_buf (
        .clk(clk), .rstn(rstn), .clr(c_clr), .shift_en(1'b0), .din('0),
        .load_en(c_load), .load_data(e_data), .cmp_data(e_data),
        .data(c_data), .cnt(c_cnt), .eq(c_eq)
    );

    assign e_full     = (e_cnt == 4'(PIN_LEN));
    assign c_full     = (c_cnt == 4'(PIN_LEN));
    assign timer_zero = (timer_q == '0);

    assign ev_clr = bus.btn_clear;
    assign ev_ent = bus.btn_enter & ~bus.btn_clear;
    assign ev_set = bus.btn_setpw & ~bus.btn_enter & ~bus.btn_clear;
    assign ev_dig = bus.input_v & is_digit(bus.index)
                  & ~bus.btn_setpw & ~bus.btn_enter & ~bus.btn_clear;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            fail_q   <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            match_q  <= 1'b0;
            stored_q <= DEFAULT_PIN;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            fail_q  <= fail_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            match_q <= e_full & e_eq;
            if (pin_we) stored_q <= c_data;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_zero ? timer_q : timer_q - TW'(1);
        fail_d  = fail_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        e_clr   = 1'b0;
        e_shift = 1'b0;
        c_clr   = 1'b0;
        c_load  = 1'b0;
        pin_we  = 1'b0;

        if (ev_dig && (state_q inside {ST_IDLE, ST_ENTRY, ST_SET_NEW, ST_SET_CONFIRM})) begin
            if (e_full) begin
                err_d = 1'b1;
            end else begin
                e_shift = 1'b1;
                ack_d   = 1'b1;
                timer_d = T_ENTRY;
                if (state_q == ST_IDLE) state_d = ST_ENTRY;
            end
        end

        case (state_q)
            ST_IDLE: ;
            ST_ENTRY, ST_SET_NEW, ST_SET_CONFIRM: begin
                if (ev_clr) begin
                    e_clr = 1'b1;
                    ack_d = 1'b1;
                    if (state_q == ST_ENTRY) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_UNLOCKED;
                        timer_d = T_UNLOCK;
                    end
                end else if (ev_ent) begin
                    if (state_q == ST_ENTRY) begin
                        state_d = ST_CHECK;
                    end else if (state_q == ST_SET_NEW) begin
                        if (e_full) begin
                            c_load  = 1'b1;
                            e_clr   = 1'b1;
                            ack_d   = 1'b1;
                            state_d = ST_SET_CONFIRM;
                            timer_d = T_ENTRY;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        e_clr   = 1'b1;
                        state_d = ST_IDLE;
                        if (e_full && c_full && c_eq) begin
                            pin_we = 1'b1;
                            ack_d  = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end else if (!ev_dig && timer_zero) begin
                    e_clr   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                e_clr = 1'b1;
                if (match_q) begin
                    state_d = ST_UNLOCKED;
                    fail_d  = '0;
                    ack_d   = 1'b1;
                    timer_d = T_UNLOCK;
                end else if (fail_q >= 4'(MAX_FAIL - 1)) begin
                    state_d = ST_LOCKOUT;
                    fail_d  = 4'(MAX_FAIL);
                    err_d   = 1'b1;
                    timer_d = T_LOCKOUT;
                end else begin
                    state_d = ST_IDLE;
                    fail_d  = fail_q + 4'd1;
                    err_d   = 1'b1;
                end
            end
            ST_UNLOCKED: begin
                if (timer_zero) begin
                    state_d = ST_IDLE;
                end else if (ev_set) begin
                    state_d = ST_SET_NEW;
                    ack_d   = 1'b1;
                    c_clr   = 1'b1;
                    timer_d = T_ENTRY;
                end
            end
            ST_LOCKOUT: begin
                if (timer_zero) begin
                    state_d = ST_IDLE;
                    fail_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.unlock    = (state_q == ST_UNLOCKED);
    assign bus.alarm     = (state_q == ST_LOCKOUT);
    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.digit_cnt = e_cnt;
    assign bus.fail_cnt  = fail_q;
    assign bus.state     = state_q;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// tb/tb_doorlock_ctrl.sv - directed checks of PIN entry, lockout, PIN change, timeout and reset
module tb_doorlock_ctrl;
    import doorlock_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n;

    doorlock_if bus();

    doorlock_ctrl #(
        .PIN_LEN(4), .MAX_FAIL(3), .UNLOCK_CYCLES(8), .LOCKOUT_CYCLES(16),
        .ENTRY_TIMEOUT(10), .DEFAULT_PIN(16'h1234)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic key(input logic [3:0] d);
        @(negedge clk);
        bus.input_v = 1'b1;
        bus.index   = d;
        @(negedge clk);
        bus.input_v = 1'b0;
        bus.index   = KEY_NONE;
    endtask

    // 0 = enter, 1 = clear, 2 = setpw
    task automatic press(input int which);
        @(negedge clk);
        bus.btn_enter = (which == 0);
        bus.btn_clear = (which == 1);
        bus.btn_setpw = (which == 2);
        @(negedge clk);
        bus.btn_enter = 1'b0;
        bus.btn_clear = 1'b0;
        bus.btn_setpw = 1'b0;
    endtask

    task automatic type_pin(input logic [15:0] pin, input int cnt);
        for (int i = 0; i < cnt; i++) key(pin[15-4*i -: 4]);
    endtask

    task automatic unlock_with(input string tag, input logic [15:0] pin);
        type_pin(pin, 4);
        press(0);
        @(negedge clk);
        check_eq(tag, 32'(bus.state), 3);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (bus.state != 3'd0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check_eq(tag, 32'(bus.state), 0);
    endtask

    initial begin
        bus.input_v   = 1'b0;
        bus.index     = KEY_NONE;
        bus.btn_enter = 1'b0;
        bus.btn_clear = 1'b0;
        bus.btn_setpw = 1'b0;

        #1;
        check_eq("rst_state", 32'(bus.state), 0);
        check_eq("rst_unlock", 32'(bus.unlock), 0);
        check_eq("rst_alarm", 32'(bus.alarm), 0);
        check_eq("rst_ack", 32'(bus.ack), 0);
        check_eq("rst_err", 32'(bus.err), 0);
        check_eq("rst_digit_cnt", 32'(bus.digit_cnt), 0);
        check_eq("rst_fail_cnt", 32'(bus.fail_cnt), 0);
        @(negedge clk);
        rstn = 1'b1;

        // correct PIN
        for (int i = 0; i < 4; i++) begin
            key(4'(i + 1));
            check_eq("t1_digit_ack", 32'(bus.ack), 1);
            check_eq("t1_digit_cnt", 32'(bus.digit_cnt), i + 1);
        end
        check_eq("t1_entry", 32'(bus.state), 1);
        press(0);
        check_eq("t1_check", 32'(bus.state), 2);
        @(negedge clk);
        check_eq("t1_ok_ack", 32'(bus.ack), 1);
        check_eq("t1_digit_clr", 32'(bus.digit_cnt), 0);
        n = 0;
        while (bus.unlock && n < 50) begin
            n++;
            @(negedge clk);
        end
        check_eq("t1_unlock_len", 32'(n), 8);
        check_eq("t1_idle", 32'(bus.state), 0);
        check_eq("t1_fail", 32'(bus.fail_cnt), 0);

        // three wrong PINs -> lockout
        for (int k = 0; k < 3; k++) begin
            type_pin(16'h1235, 4);
            press(0);
            @(negedge clk);
            check_eq("t2_err", 32'(bus.err), 1);
            if (k < 2) begin
                check_eq("t2_fail_cnt", 32'(bus.fail_cnt), k + 1);
                check_eq("t2_idle", 32'(bus.state), 0);
            end else begin
                check_eq("t2_lockout", 32'(bus.state), 4);
                check_eq("t2_alarm", 32'(bus.alarm), 1);
            end
        end
        n = 0;
        while (bus.alarm && n < 100) begin
            n++;
            if (n == 3) begin bus.input_v = 1'b1; bus.index = 4'd1; end
            if (n == 4) begin bus.input_v = 1'b0; bus.index = KEY_NONE; end
            if (n == 5) bus.btn_enter = 1'b1;
            if (n == 6) bus.btn_enter = 1'b0;
            @(negedge clk);
            if (n == 3 || n == 5) begin
                check_eq("t2_lock_ack", 32'(bus.ack), 0);
                check_eq("t2_lock_err", 32'(bus.err), 0);
            end
        end
        check_eq("t2_lockout_len", 32'(n), 16);
        check_eq("t2_after_idle", 32'(bus.state), 0);
        check_eq("t2_after_fail", 32'(bus.fail_cnt), 0);
        check_eq("t2_after_digits", 32'(bus.digit_cnt), 0);

        // overflow and short entry
        type_pin(16'h1234, 4);
        key(4'd5);
        check_eq("t3_ovf_err", 32'(bus.err), 1);
        check_eq("t3_ovf_ack", 32'(bus.ack), 0);
        check_eq("t3_ovf_cnt", 32'(bus.digit_cnt), 4);
        press(1);
        check_eq("t3_clr_ack", 32'(bus.ack), 1);
        check_eq("t3_clr_idle", 32'(bus.state), 0);
        check_eq("t3_clr_cnt", 32'(bus.digit_cnt), 0);
        type_pin(16'h1234, 3);
        press(0);
        @(negedge clk);
        check_eq("t3_short_err", 32'(bus.err), 1);
        check_eq("t3_short_fail", 32'(bus.fail_cnt), 1);

        // entry timeout, clear/enter priority, non-digit index
        key(4'd1);
        check_eq("t5_entry", 32'(bus.state), 1);
        repeat (9) @(negedge clk);
        check_eq("t5_before_timeout", 32'(bus.state), 1);
        @(negedge clk);
        check_eq("t5_timeout_idle", 32'(bus.state), 0);
        check_eq("t5_timeout_cnt", 32'(bus.digit_cnt), 0);
        check_eq("t5_timeout_fail", 32'(bus.fail_cnt), 1);
        check_eq("t5_timeout_err", 32'(bus.err), 0);
        key(4'd1);
        @(negedge clk);
        bus.btn_clear = 1'b1;
        bus.btn_enter = 1'b1;
        @(negedge clk);
        bus.btn_clear = 1'b0;
        bus.btn_enter = 1'b0;
        check_eq("t5_prio_state", 32'(bus.state), 0);
        check_eq("t5_prio_ack", 32'(bus.ack), 1);
        check_eq("t5_prio_cnt", 32'(bus.digit_cnt), 0);
        @(negedge clk);
        check_eq("t5_prio_nocheck", 32'(bus.state), 0);
        key(4'hA);
        check_eq("t5_hex_state", 32'(bus.state), 0);
        check_eq("t5_hex_ack", 32'(bus.ack), 0);
        check_eq("t5_hex_err", 32'(bus.err), 0);
        check_eq("t5_hex_cnt", 32'(bus.digit_cnt), 0);

        // PIN change: failed confirm first, then a good one
        unlock_with("t4_unlock_a", 16'h1234);
        check_eq("t4_fail_clr", 32'(bus.fail_cnt), 0);
        press(2);
        check_eq("t4_setpw_ack", 32'(bus.ack), 1);
        check_eq("t4_set_new", 32'(bus.state), 5);
        type_pin(16'h9876, 4);
        press(0);
        check_eq("t4_new_ack", 32'(bus.ack), 1);
        check_eq("t4_confirm", 32'(bus.state), 6);
        check_eq("t4_confirm_cnt", 32'(bus.digit_cnt), 0);
        type_pin(16'h9875, 4);
        press(0);
        check_eq("t4_badconf_err", 32'(bus.err), 1);
        check_eq("t4_badconf_idle", 32'(bus.state), 0);
        unlock_with("t4_old_pin_kept", 16'h1234);
        press(2);
        type_pin(16'h9876, 4);
        press(0);
        type_pin(16'h9876, 4);
        press(0);
        check_eq("t4_change_ack", 32'(bus.ack), 1);
        check_eq("t4_change_idle", 32'(bus.state), 0);
        type_pin(16'h1234, 4);
        press(0);
        @(negedge clk);
        check_eq("t4_old_rejected", 32'(bus.err), 1);
        check_eq("t4_old_fail", 32'(bus.fail_cnt), 1);
        unlock_with("t4_new_unlock", 16'h9876);

        // asynchronous reset while unlocked and while confirming
        #2 rstn = 1'b0;
        #1;
        check_eq("t6_rst_unlock", 32'(bus.unlock), 0);
        check_eq("t6_rst_state", 32'(bus.state), 0);
        check_eq("t6_rst_ack", 32'(bus.ack), 0);
        @(negedge clk);
        rstn = 1'b1;
        unlock_with("t6_default_pin", 16'h1234);
        press(2);
        type_pin(16'h5555, 4);
        press(0);
        check_eq("t6_confirm", 32'(bus.state), 6);
        type_pin(16'h5555, 2);
        #2 rstn = 1'b0;
        #1;
        check_eq("t6_rst2_state", 32'(bus.state), 0);
        check_eq("t6_rst2_cnt", 32'(bus.digit_cnt), 0);
        check_eq("t6_rst2_unlock", 32'(bus.unlock), 0);
        @(negedge clk);
        rstn = 1'b1;
        unlock_with("t6_pin_unchanged", 16'h1234);
        wait_idle("t6_final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/doorlock_ctrl.md
Name: doorlock_ctrl

Overview:
Door-lock sequencing FSM fed by the keypad front end's one-cycle input_v pulse and 4-bit digit index. Collects a PIN, compares it with a stored PIN, drives the unlock output for a fixed time, and enforces a lockout after repeated failures. While unlocked, it supports a two-pass PIN change (new PIN, then confirm).

Parameters:
PIN_LEN, 4, digits per PIN (1..8)
MAX_FAIL, 3, consecutive failures that trigger lockout
UNLOCK_CYCLES, 1000, unlock hold time in clk cycles
LOCKOUT_CYCLES, 5000, lockout duration in clk cycles
ENTRY_TIMEOUT, 2000, idle cycles allowed between keys before the entry is abandoned
DEFAULT_PIN, 16'h1234, reset PIN, 4 bits per digit (BCD), first digit in the MS nibble

Ports:
clk  input  1  clock
rstn  input  1  reset; asynchronous, active-low
input_v  input  1  one-cycle digit strobe from the keypad front end
index  input  4  digit value; valid only when input_v=1; values >9 are ignored
btn_enter  input  1  one-cycle enter pulse
btn_clear  input  1  one-cycle clear pulse
btn_setpw  input  1  one-cycle "change PIN" pulse
unlock  output  1  door actuator; high only in UNLOCKED
alarm  output  1  high only in LOCKOUT
ack  output  1  one-cycle pulse on each accepted digit or command
err  output  1  one-cycle pulse on any rejected or failed operation
digit_cnt  output  4  number of digits currently buffered
fail_cnt  output  4  consecutive failure count
state  output  3  current FSM state code

Behaviour:
- Reset values: state=IDLE; all outputs 0; entry buffer and confirm buffer 0; stored PIN=DEFAULT_PIN. Reset mid-operation aborts everything, including a pending PIN change.
- State codes: IDLE=0, ENTRY=1, CHECK=2, UNLOCKED=3, LOCKOUT=4, SET_NEW=5, SET_CONFIRM=6.
- Same-cycle event priority: btn_clear > btn_enter > btn_setpw > input_v. Lower-priority events in that cycle are dropped silently.
- Digit accept (IDLE, ENTRY, SET_NEW, SET_CONFIRM), when input_v=1 and index<=9:
  - If digit_cnt<PIN_LEN: shift the digit into the buffer LSB nibble, digit_cnt+1, ack next cycle.
  - If the buffer is full: no change, err pulse.
  - In IDLE, an accepted digit moves to ENTRY.
  - index>9 is ignored with no ack and no err.
- Timer: one shared down-counter, wide enough for the largest cycle parameter.
  - Reloaded to ENTRY_TIMEOUT on entering ENTRY, SET_NEW or SET_CONFIRM, and on every accepted digit.
  - Reaching 0 in any of those states: clear the buffer, digit_cnt=0, go to IDLE. fail_cnt is unchanged, no err.
- btn_clear:
  - In ENTRY: clear the buffer, go to IDLE, ack.
  - In SET_NEW or SET_CONFIRM: clear the buffer, return to UNLOCKED with the timer reloaded to UNLOCK_CYCLES.
  - Ignored elsewhere.
- btn_enter in ENTRY: go to CHECK (one cycle, registered compare).
  - Match requires digit_cnt==PIN_LEN and buffer==stored PIN.
  - Match: go to UNLOCKED, fail_cnt=0, ack, timer=UNLOCK_CYCLES.
  - Mismatch with fail_cnt+1==MAX_FAIL: go to LOCKOUT, err, timer=LOCKOUT_CYCLES.
  - Other mismatch: fail_cnt+1, err, go to IDLE.
  - The buffer is always cleared on leaving CHECK.
  - btn_enter in IDLE is ignored.
- UNLOCKED:
  - unlock=1 and the timer counts down; reaching 0 goes to IDLE.
  - btn_setpw goes to SET_NEW with ack. Digits and btn_enter are ignored.
- SET_NEW: btn_enter with digit_cnt==PIN_LEN copies the buffer to the confirm buffer, clears the buffer and goes to SET_CONFIRM with ack. Short entry: err, stay, buffer kept.
- SET_CONFIRM: btn_enter with digit_cnt==PIN_LEN and buffer==confirm:
  - Match: the stored PIN is written on the same edge, ack, go to IDLE.
  - Any mismatch or short entry: err, stored PIN unchanged, go to IDLE.
- LOCKOUT: alarm=1; all key inputs are ignored with no ack/err. When the timer reaches 0: fail_cnt=0, go to IDLE.
- Timer reaching 0 while unlock time is being counted means exactly UNLOCK_CYCLES cycles with unlock=1.
- fail_cnt saturates at MAX_FAIL.

Decomposition:
- Shared package doorlock_pkg: state encoding constants and the digit width constant (4). Also holds the keypad index for "no key" (4'hF), shared with the keypad front end.
- One natural sub-module: pin_buffer. It holds the shift register, digit_cnt, full flag, clear and compare-equal output, and is instantiated twice (entry and confirm). A copy-load port on the confirm instance is acceptable.

Test Plan:
Use PIN_LEN=4, MAX_FAIL=3, UNLOCK_CYCLES=8, LOCKOUT_CYCLES=16, ENTRY_TIMEOUT=10, DEFAULT_PIN=16'h1234.
1. Correct PIN: digits 1,2,3,4 then enter -> ack per digit; CHECK for one cycle; unlock=1 for exactly 8 cycles; then state=IDLE, fail_cnt=0.
2. Wrong PIN three times: 1,2,3,5 + enter, three times -> err each time; fail_cnt goes 1, 2, then LOCKOUT with alarm=1 for 16 cycles. Digit/enter pulses during lockout produce no ack/err. Afterwards IDLE with fail_cnt=0.
3. Overflow and short entry: five digits -> fifth gives err and digit_cnt stays 4. Separately, 1,2,3 + enter -> failure, fail_cnt=1.
4. PIN change: unlock, setpw, 9,8,7,6 + enter, 9,8,7,6 + enter -> stored PIN is 16'h9876. Then 1,2,3,4 fails and 9,8,7,6 unlocks. A confirm of 9,8,7,5 instead -> err, PIN stays 16'h1234.
5. Timeout and priority: digit 1 then 10 idle cycles -> IDLE, digit_cnt=0, fail_cnt unchanged. Clear+enter in the same cycle in ENTRY -> clear wins, no CHECK. Index 4'hA with input_v -> no effect.
6. Reset mid-operation: assert rstn low during UNLOCKED and during SET_CONFIRM -> all outputs 0 immediately (asynchronously), stored PIN back to 16'h1234.
